// File: rtl/phase_timer.sv
// Phase timing responder for the traffic light controller: decodes the active phase,
// times it in whole seconds and returns done pulses, walk countdown, beeper and night blink.
module phase_timer #(
  parameter int TICK_DIV   = 50000000,
  parameter int GREEN_S    = 10,
  parameter int YELLOW_S   = 3,
  parameter int RED_S      = 5,
  parameter int WALK_S     = 9,
  parameter int BEEP_ON    = 12500000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       green_led,
  input  logic       yellow_led,
  input  logic       red_led,
  input  logic       walk_enable,
  input  logic       blink_enable,
  output logic       green_done,
  output logic       yellow_done,
  output logic       red_done,
  output logic       walk_done,
  output logic [3:0] walk_count,
  output logic       beep,
  output logic       blink_out,
  output logic       sec_tick,
  output logic       phase_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BEEP_LIM   = PW'(BEEP_ON);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_GREEN  = 3'd1;
  localparam logic [2:0] PH_YELLOW = 3'd2;
  localparam logic [2:0] PH_RED    = 3'd3;
  localparam logic [2:0] PH_WALK   = 3'd4;
  localparam logic [2:0] PH_NIGHT  = 3'd5;

  logic [2:0]    phase_q, phase_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [3:0]    remaining_q, remaining_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          beep_q, beep_d;
  logic          sec_tick_q, sec_tick_d;
  logic          phase_err_q, phase_err_d;
  logic          green_done_q, green_done_d;
  logic          yellow_done_q, yellow_done_d;
  logic          red_done_q, red_done_d;
  logic          walk_done_q, walk_done_d;

  logic [2:0] phase_now;
  logic       illegal;
  logic       entry;
  logic       timed;
  logic       tick;

  function automatic logic [3:0] phase_duration(input logic [2:0] ph);
    case (ph)
      PH_GREEN:  phase_duration = 4'(GREEN_S);
      PH_YELLOW: phase_duration = 4'(YELLOW_S);
      PH_RED:    phase_duration = 4'(RED_S);
      PH_WALK:   phase_duration = 4'(WALK_S);
      default:   phase_duration = 4'd0;
    endcase
  endfunction

  // The legal encodings are mutually exclusive, so a flat case keeps the priority order.
  always_comb begin
    phase_now = PH_IDLE;
    illegal   = 1'b0;
    case ({green_led, yellow_led, red_led, walk_enable, blink_enable})
      5'b00110: phase_now = PH_WALK;
      5'b00001: phase_now = PH_NIGHT;
      5'b10000: phase_now = PH_GREEN;
      5'b01000: phase_now = PH_YELLOW;
      5'b00100: phase_now = PH_RED;
      5'b00000: phase_now = PH_IDLE;
      default:  illegal   = 1'b1;
    endcase
  end

  assign entry = (phase_now != phase_q);
  assign timed = (phase_q == PH_GREEN) || (phase_q == PH_YELLOW) ||
                 (phase_q == PH_RED)   || (phase_q == PH_WALK);
  assign tick  = timed && (prescale_q == TICK_LAST);

  always_comb begin
    phase_d       = phase_q;
    prescale_d    = prescale_q;
    remaining_d   = remaining_q;
    blink_cnt_d   = blink_cnt_q;
    blink_d       = blink_q;
    beep_d        = 1'b0;
    sec_tick_d    = 1'b0;
    phase_err_d   = illegal;
    green_done_d  = 1'b0;
    yellow_done_d = 1'b0;
    red_done_d    = 1'b0;
    walk_done_d   = 1'b0;

    // An entry wins over a coincident terminal tick, so the old phase never reports done.
    if (entry) begin
      phase_d     = phase_now;
      prescale_d  = '0;
      remaining_d = phase_duration(phase_now);
      blink_cnt_d = '0;
      blink_d     = (phase_now == PH_NIGHT);
    end else begin
      if (timed) begin
        prescale_d = tick ? '0 : prescale_q + 1'b1;
        if (tick && (remaining_q != 4'd0)) begin
          remaining_d = remaining_q - 4'd1;
          sec_tick_d  = 1'b1;
          if (remaining_q == 4'd1) begin
            case (phase_q)
              PH_GREEN:  green_done_d  = 1'b1;
              PH_YELLOW: yellow_done_d = 1'b1;
              PH_RED:    red_done_d    = 1'b1;
              PH_WALK:   walk_done_d   = 1'b1;
              default:   ;
            endcase
          end
        end
      end
      beep_d = (phase_q == PH_WALK) && (remaining_q != 4'd0) && (prescale_q < BEEP_LIM);
      if (phase_q == PH_NIGHT) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= PH_IDLE;
      prescale_q    <= '0;
      remaining_q   <= 4'd0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      beep_q        <= 1'b0;
      sec_tick_q    <= 1'b0;
      phase_err_q   <= 1'b0;
      green_done_q  <= 1'b0;
      yellow_done_q <= 1'b0;
      red_done_q    <= 1'b0;
      walk_done_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      prescale_q    <= prescale_d;
      remaining_q   <= remaining_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      beep_q        <= beep_d;
      sec_tick_q    <= sec_tick_d;
      phase_err_q   <= phase_err_d;
      green_done_q  <= green_done_d;
      yellow_done_q <= yellow_done_d;
      red_done_q    <= red_done_d;
      walk_done_q   <= walk_done_d;
    end
  end

  assign green_done  = green_done_q;
  assign yellow_done = yellow_done_q;
  assign red_done    = red_done_q;
  assign walk_done   = walk_done_q;
  assign walk_count  = (phase_q == PH_WALK) ? remaining_q : 4'd0;
  assign beep        = beep_q;
  assign blink_out   = blink_q;
  assign sec_tick    = sec_tick_q;
  assign phase_err   = phase_err_q;

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: directed phase sequences plus random phase hopping, checked
// against an elapsed-time model of what each output should show k cycles after entry.
module tb_phase_timer;

  localparam int TD = 10;
  localparam int GS = 3;
  localparam int YS = 2;
  localparam int RS = 5;
  localparam int WS = 4;
  localparam int BP = 3;
  localparam int BH = 5;

  localparam int M_IDLE    = 0;
  localparam int M_GREEN   = 1;
  localparam int M_YELLOW  = 2;
  localparam int M_RED     = 3;
  localparam int M_WALK    = 4;
  localparam int M_NIGHT   = 5;
  localparam int M_ILLEGAL = 6;

  logic       clk;
  logic       reset_n;
  logic       green_led, yellow_led, red_led, walk_enable, blink_enable;
  logic       green_done, yellow_done, red_done, walk_done;
  logic [3:0] walk_count;
  logic       beep, blink_out, sec_tick, phase_err;

  int   compared;
  int   mismatched;
  int   m_phase;
  int   m_k;
  logic exp_beep;
  logic exp_err;

  phase_timer #(
    .TICK_DIV(TD), .GREEN_S(GS), .YELLOW_S(YS), .RED_S(RS),
    .WALK_S(WS), .BEEP_ON(BP), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .green_led(green_led), .yellow_led(yellow_led), .red_led(red_led),
    .walk_enable(walk_enable), .blink_enable(blink_enable),
    .green_done(green_done), .yellow_done(yellow_done),
    .red_done(red_done), .walk_done(walk_done),
    .walk_count(walk_count), .beep(beep), .blink_out(blink_out),
    .sec_tick(sec_tick), .phase_err(phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int decodePhase();
    if (walk_enable && red_led && !green_led && !yellow_led && !blink_enable) return M_WALK;
    if (blink_enable && !green_led && !yellow_led && !red_led && !walk_enable) return M_NIGHT;
    if (green_led && !yellow_led && !red_led && !walk_enable && !blink_enable) return M_GREEN;
    if (yellow_led && !green_led && !red_led && !walk_enable && !blink_enable) return M_YELLOW;
    if (red_led && !green_led && !yellow_led && !walk_enable && !blink_enable) return M_RED;
    if (!green_led && !yellow_led && !red_led && !walk_enable && !blink_enable) return M_IDLE;
    return M_ILLEGAL;
  endfunction

  function automatic int durOf(int p);
    case (p)
      M_GREEN:  return GS;
      M_YELLOW: return YS;
      M_RED:    return RS;
      M_WALK:   return WS;
      default:  return 0;
    endcase
  endfunction

  // Seconds still to go k cycles after entry; the first second ends at k = TD.
  function automatic int remOf(int p, int k);
    int v;
    if (durOf(p) == 0) return 0;
    v = durOf(p) - (k - 1) / TD;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic modelReset();
    m_phase  = M_IDLE;
    m_k      = 0;
    exp_beep = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic check1(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s at t=%0t: observed=%0d expected=%0d", tag, $time, obs, expv);
    end
  endtask

  task automatic checkOutput();
    int  d;
    logic t;
    if (!reset_n) modelReset();
    d = durOf(m_phase);
    t = (d != 0) && (m_k > TD) && (((m_k - 1) % TD) == 0) && (((m_k - 1) / TD) <= d);
    check1("green_done",  4'(green_done),  4'(m_phase == M_GREEN  && m_k == d * TD + 1));
    check1("yellow_done", 4'(yellow_done), 4'(m_phase == M_YELLOW && m_k == d * TD + 1));
    check1("red_done",    4'(red_done),    4'(m_phase == M_RED    && m_k == d * TD + 1));
    check1("walk_done",   4'(walk_done),   4'(m_phase == M_WALK   && m_k == d * TD + 1));
    check1("sec_tick",    4'(sec_tick),    4'(t));
    check1("walk_count",  walk_count,      4'((m_phase == M_WALK) ? remOf(m_phase, m_k) : 0));
    check1("beep",        4'(beep),        4'(exp_beep));
    check1("blink_out",   4'(blink_out),   4'(m_phase == M_NIGHT && (((m_k - 1) / BH) % 2) == 0));
    check1("phase_err",   4'(phase_err),   4'(exp_err));
  endtask

  task automatic modelUpdate();
    int pn;
    logic ill;
    if (!reset_n) return;
    pn  = decodePhase();
    ill = (pn == M_ILLEGAL);
    if (ill) pn = M_IDLE;
    if (pn != m_phase) begin
      exp_beep = 1'b0;
      m_phase  = pn;
      m_k      = 1;
    end else begin
      exp_beep = (m_phase == M_WALK) && (remOf(m_phase, m_k) > 0) && (((m_k - 1) % TD) < BP);
      m_k++;
    end
    exp_err = ill;
  endtask

  task automatic applyStimulus(input logic g, input logic y, input logic r,
                               input logic w, input logic b);
    green_led    = g;
    yellow_led   = y;
    red_led      = r;
    walk_enable  = w;
    blink_enable = b;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput();
      modelUpdate();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    #1;
    checkOutput();
    runCycles(2);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0] bits;
    int sel;
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    modelReset();
    runCycles(3);

    $display("[TB] green out of reset, then long hold");
    applyStimulus(1, 0, 0, 0, 0);
    reset_n = 1'b1;
    runCycles(140);
    applyStimulus(0, 0, 0, 0, 0);
    runCycles(4);

    $display("[TB] walk phase countdown and beeper");
    applyStimulus(0, 0, 1, 1, 0);
    runCycles(65);

    $display("[TB] night blink and exit");
    applyStimulus(0, 0, 0, 0, 1);
    runCycles(23);
    applyStimulus(0, 0, 0, 0, 0);
    runCycles(3);

    $display("[TB] illegal combination then yellow");
    applyStimulus(1, 1, 0, 0, 0);
    runCycles(15);
    applyStimulus(0, 1, 0, 0, 0);
    runCycles(30);
    applyStimulus(0, 0, 0, 0, 0);
    runCycles(2);

    $display("[TB] phase change on terminal tick");
    applyStimulus(0, 1, 0, 0, 0);
    runCycles(YS * TD);
    applyStimulus(0, 0, 1, 0, 0);
    runCycles(RS * TD + 5);

    $display("[TB] asynchronous reset mid-walk, then restart");
    applyStimulus(0, 0, 1, 1, 0);
    runCycles(25);
    pulseReset();
    runCycles(WS * TD + 5);

    $display("[TB] random phase hopping");
    for (int s = 0; s < 40; s++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: applyStimulus(0, 0, 0, 0, 0);
        1: applyStimulus(1, 0, 0, 0, 0);
        2: applyStimulus(0, 1, 0, 0, 0);
        3: applyStimulus(0, 0, 1, 0, 0);
        4: applyStimulus(0, 0, 1, 1, 0);
        5: applyStimulus(0, 0, 0, 0, 1);
        default: begin
          bits = 5'($urandom_range(0, 31));
          applyStimulus(bits[4], bits[3], bits[2], bits[1], bits[0]);
        end
      endcase
      if ($urandom_range(0, 15) == 0) pulseReset();
      runCycles(int'($urandom_range(1, 60)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
Timing responder for the traffic light controller. It decodes the controller's current phase from the light and enable signals, times each phase in whole seconds, and returns one-cycle green_done, yellow_done, red_done or walk_done pulses. It also drives the walk countdown digit, the walk beeper and the night-mode blink waveform.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick (>=2)
GREEN_S, 10, green duration in seconds (1..15)
YELLOW_S, 3, yellow duration in seconds (1..15)
RED_S, 5, red duration in seconds (1..15)
WALK_S, 9, walk duration in seconds (1..15)
BEEP_ON, 12500000, cycles beep is high at the start of each walk second (1..TICK_DIV-1)
BLINK_HALF, 25000000, night blink half-period in cycles (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
green_led  in  1  controller green indication
yellow_led  in  1  controller yellow indication
red_led  in  1  controller red indication
walk_enable  in  1  controller walk phase
blink_enable  in  1  controller night phase
green_done  out  1  one-cycle pulse, green time expired
yellow_done  out  1  one-cycle pulse, yellow time expired
red_done  out  1  one-cycle pulse, red time expired
walk_done  out  1  one-cycle pulse, walk time expired
walk_count  out  4  seconds remaining in walk, 0 otherwise
beep  out  1  walk beeper drive
blink_out  out  1  night blink waveform
sec_tick  out  1  one-cycle pulse per second of an active timed phase
phase_err  out  1  high while input combination is illegal

Behaviour:
- Reset: asynchronous. All outputs are 0. The prescaler and remaining count are 0. phase_q is IDLE.
- Combinational phase decode (phase_now), in priority order:
  - WALK: walk_enable=1 and red_led=1, green/yellow/blink_enable=0.
  - NIGHT: blink_enable=1 and all lights and walk_enable=0.
  - GREEN / YELLOW / RED: exactly that one light is 1, everything else 0.
  - IDLE: all inputs 0.
  - Any other combination is ILLEGAL. ILLEGAL is treated as IDLE, and phase_err (registered) is 1 while it persists.
- Entry cycle E: any cycle where phase_now != phase_q. At the posedge ending E:
  - phase_q <= phase_now, prescale <= 0.
  - remaining <= duration of the new phase (0 for IDLE/NIGHT).
  - All done outputs <= 0.
- Counting (timed phases only, not on an entry cycle):
  - prescale counts 0..TICK_DIV-1 and wraps. A tick is prescale==TICK_DIV-1.
  - On a tick with remaining>0: remaining decrements and sec_tick <= 1 for one cycle.
  - On the tick where remaining goes 1 to 0, the done output matching phase_q is registered high for exactly one cycle. It is high during cycle E + DUR*TICK_DIV + 1.
  - After reaching 0, remaining holds at 0. No further done pulses or sec_ticks occur until a new entry.
- Simultaneous events: an entry on the same cycle as a terminal tick takes priority, so no done pulse is issued for the old phase.
- IDLE / ILLEGAL: prescaler held at 0. No ticks, no dones. beep=0, blink_out=0.
- walk_count: equals remaining while phase_q==WALK, else 0. It shows WALK_S immediately after entry and 0 at walk_done.
- beep: 1 only in WALK with remaining>0 and prescale<BEEP_ON; else 0. It is registered, so there is 1 cycle of latency.
- blink_out: only in NIGHT.
  - Set to 1 on NIGHT entry.
  - Toggles every BLINK_HALF cycles using an independent counter that is cleared on entry.
  - 0 in all other phases.
- Reset mid-phase: everything clears. After release, the first cycle with a legal non-IDLE phase is an entry cycle and a full-duration timing restarts.
- Widths:
  - Prescale width is clog2(TICK_DIV); the blink counter width is clog2(BLINK_HALF+1).
  - remaining is 4 bits and never underflows.

Test Plan:
- TICK_DIV=10, GREEN_S=3; release reset with green_led=1 -> green_done high for exactly one cycle at cycle 31 after the entry cycle; sec_tick pulses at cycles 11, 21, 31.
- Hold green_led=1 for 100 cycles after green_done -> no further done pulses or sec_ticks.
- WALK_S=4, BEEP_ON=3; drive red_led=1 and walk_enable=1 -> walk_count reads 4,3,2,1,0 at each tick; beep high for 3 cycles per second; walk_done fires once, red_done never fires.
- BLINK_HALF=5; drive blink_enable=1 -> blink_out=1 at entry+1, toggles every 5 cycles, and no done outputs fire. Clear blink_enable -> blink_out=0 the next cycle.
- Drive green_led=1 and yellow_led=1 together -> phase_err=1, no ticks. Return to yellow_led only -> phase_err=0 and yellow_done fires after YELLOW_S*TICK_DIV+1 cycles.
- Change phase exactly on the terminal tick cycle -> no done pulse for the old phase, and the new phase times its full duration. Assert reset_n low mid-red -> all outputs 0 immediately (asynchronous).
